tt_um_lfsr_checker: RTL and testbench

Receive-side companion to the 8-bit LFSR pattern generator: accepts the generator's parallel word stream on `ui_in`, self-synchronises to it, then flags and counts every word that departs from the x^8+x^6+x^5+x^4+1 sequence. It sits at the far end of a board or chip-to-chip link as a pattern checker. It reports lock state and errors on the Tiny Tapeout user pins.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/tt_um_lfsr_popcount8.sv | 14 +
 rtl/tt_um_lfsr_checker.sv | 144 ++++++++++++++
 tb/tb_tt_um_lfsr_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and checker:
// width, tap mask, step function and checker state encoding.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_e;

    // x^8+x^6+x^5+x^4+1: shift left, feedback is the parity of the tapped bits
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] w);
        return {w[LFSR_WIDTH-2:0], ^(w & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tt_um_lfsr_popcount8.sv
// Combinational 8-bit population count; used by the bit-error build of the checker.
module lfsr_popcount8 (
    input  logic [7:0] word,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, word[i]};
        end
    end

endmodule

// File: rtl/tt_um_lfsr_checker.sv
// Self-synchronising LFSR pattern checker with lock tracking and a saturating error counter.
// Define LFSR_CHK_BITERR_EN to count bit errors instead of word errors.
module tt_um_lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
    localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

    chk_state_e state_q, state_d;
    logic [7:0] pred_q, pred_d;
    logic [3:0] match_q, match_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] err_q, err_d;
    logic       err_pulse_q, err_pulse_d;
    logic       locked_q, verifying_q;
    logic       inc_en;
    logic       clr_err;
    logic       match;
    logic [8:0] inc_amt;
    logic [8:0] err_sum;
    logic       unused_uio;

    assign clr_err    = uio_in[7];
    assign unused_uio = ^uio_in[6:0];
    assign match      = (ui_in == pred_q);

`ifdef LFSR_CHK_BITERR_EN
    logic [3:0] bit_errs;

    lfsr_popcount8 u_popcount (
        .word  (ui_in ^ pred_q),
        .count (bit_errs)
    );

    assign inc_amt = {5'b00000, bit_errs};
`else
    assign inc_amt = 9'd1;
`endif

    assign err_sum = {1'b0, err_q} + inc_amt;

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        inc_en      = 1'b0;
        if (ena) begin
            unique case (state_q)
                HUNT: begin
                    // The all-zero word is the LFSR dead state; never seed from it.
                    if (ui_in != 8'h00) begin
                        pred_d  = lfsr_next(ui_in);
                        match_d = 4'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        pred_d  = lfsr_next(pred_q);
                        match_d = match_q + 4'd1;
                        if (match_d == LockCnt) begin
                            state_d = LOCKED;
                        end
                    end else if (ui_in != 8'h00) begin
                        pred_d  = lfsr_next(ui_in);
                        match_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-running: a corrupted word must not disturb later predictions.
                    pred_d = lfsr_next(pred_q);
                    if (match) begin
                        miss_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        inc_en      = 1'b1;
                        miss_d      = miss_q + 4'd1;
                        if (miss_d == LossCnt) begin
                            state_d = HUNT;
                            miss_d  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (inc_en) begin
            err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        end
        if (clr_err) begin
            err_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            pred_q      <= 8'h00;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            err_q       <= 8'h00;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            verifying_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= (state_d == LOCKED);
            verifying_q <= (state_d == VERIFY);
        end
    end

    assign uo_out  = err_q;
    assign uio_out = {5'b00000, err_pulse_q, verifying_q, locked_q};
    assign uio_oe  = 8'h07;

endmodule

// File: tb/tb_tt_um_lfsr_checker.sv
// Randomised and directed bench for tt_um_lfsr_checker against an in-bench behavioural model.
module tb_tt_um_lfsr_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_lfsr_checker #(
        .LOCK_COUNT (LOCK),
        .LOSS_COUNT (LOSS)
    ) dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    // Model: phase 0 searching, 1 confirming, 2 locked.
    typedef struct {
        int         phase;
        logic [7:0] pred;
        int         good;
        int         bad;
        int         errs;
        bit         pulse;
    } model_t;

    model_t m;

    function automatic logic [7:0] nxt(input logic [7:0] w);
        int v;
        v = ((int'(w) * 2) % 256) + ($countones(w & 8'hB8) % 2);
        return v[7:0];
    endfunction

    function automatic model_t model_step(input model_t s, input logic [7:0] ui,
                                          input logic en, input logic clr);
        model_t n;
        int     cost;
        n = s;
        n.pulse = 1'b0;
`ifdef LFSR_CHK_BITERR_EN
        cost = $countones(ui ^ s.pred);
`else
        cost = 1;
`endif
        if (en) begin
            if (s.phase == 0) begin
                if (ui != 8'h00) begin
                    n.phase = 1;
                    n.pred  = nxt(ui);
                    n.good  = 0;
                end
            end else if (s.phase == 1) begin
                if (ui == s.pred) begin
                    n.pred = nxt(s.pred);
                    n.good = s.good + 1;
                    if (n.good >= LOCK) n.phase = 2;
                end else if (ui == 8'h00) begin
                    n.phase = 0;
                end else begin
                    n.pred = nxt(ui);
                    n.good = 0;
                end
            end else begin
                n.pred = nxt(s.pred);
                if (ui == s.pred) begin
                    n.bad = 0;
                end else begin
                    n.pulse = 1'b1;
                    n.errs  = (s.errs + cost > 255) ? 255 : s.errs + cost;
                    n.bad   = s.bad + 1;
                    if (n.bad >= LOSS) begin
                        n.phase = 0;
                        n.bad   = 0;
                    end
                end
            end
        end
        if (clr) n.errs = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{phase: 0, pred: 8'h00, good: 0, bad: 0, errs: 0, pulse: 1'b0};
        end else begin
            m <= model_step(m, ui_in, ena, uio_in[7]);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [7:0] exp_uo, exp_uio;
        exp_uo  = 8'(m.errs);
        exp_uio = {5'b00000, m.pulse, m.phase == 1, m.phase == 2};
        checks++;
        if (uo_out !== exp_uo || uio_out !== exp_uio || uio_oe !== 8'h07) begin
            errors++;
            $display("FAIL cycle t=%0t: uo_out=%02h uio_out=%02h uio_oe=%02h expected %02h %02h 07",
                     $time, uo_out, uio_out, uio_oe, exp_uo, exp_uio);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ui, input logic en, input logic clr);
        @(negedge clk);
        ui_in  = ui;
        ena    = en;
        uio_in = {clr, 7'($urandom)};
        @(posedge clk);
        #1;
    endtask

    task automatic lock_from_01();
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h04, 1'b1, 1'b0);
        drive(8'h08, 1'b1, 1'b0);
        check("pre_lock_status", uio_out, 8'h02);
        drive(8'h11, 1'b1, 1'b0);
        check("lock_status", uio_out, 8'h01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        logic [7:0] mask;
        int         run;
        int         k;

        repeat (3) @(posedge clk);
        #1;
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio", uio_out, 8'h00);
        check("reset_oe", uio_oe, 8'h07);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock, then a single corrupted word and a following good word.
        lock_from_01();
        check("lock_uo", uo_out, 8'h00);
        drive(8'h23, 1'b1, 1'b0);
        drive(8'h46, 1'b1, 1'b0);
        check("err_status", uio_out, 8'h05);
        check("err_count", uo_out, 8'h01);
        drive(8'h8E, 1'b1, 1'b0);
        check("after_err_status", uio_out, 8'h01);
        check("after_err_count", uo_out, 8'h01);

        // Zero word in place of 1C.
        drive(8'h00, 1'b1, 1'b0);
        check("zero_word_status", uio_out, 8'h05);
`ifdef LFSR_CHK_BITERR_EN
        check("zero_word_count", uo_out, 8'h04);
`else
        check("zero_word_count", uo_out, 8'h02);
`endif
        drive(8'h38, 1'b1, 1'b0);
        check("match_38", uio_out, 8'h01);

        // Three consecutive one-bit errors drop lock.
        drive(8'h70, 1'b1, 1'b0);
        drive(8'hE3, 1'b1, 1'b0);
        check("loss_pending", uio_out, 8'h05);
        drive(8'hC5, 1'b1, 1'b0);
        check("loss_status", uio_out, 8'h04);
`ifdef LFSR_CHK_BITERR_EN
        check("loss_count", uo_out, 8'h07);
`else
        check("loss_count", uo_out, 8'h05);
`endif
        drive(8'h00, 1'b1, 1'b0);
        check("hunt_after_loss", uio_out, 8'h00);

        // Saturation: climb to FE without losing lock, then two more errors.
        lock_from_01();
        run = 0;
        for (int i = 0; i < 1200 && m.errs < 254; i++) begin
            if (run == 2) begin
                drive(m.pred, 1'b1, 1'b0);
                run = 0;
            end else begin
                k = 254 - m.errs;
                mask = (k >= 8) ? 8'hFF : 8'(8'hFF >> (8 - k));
                drive(m.pred ^ mask, 1'b1, 1'b0);
                run++;
            end
        end
        check("count_fe", uo_out, 8'hFE);
        drive(m.pred, 1'b1, 1'b0);
        drive(m.pred ^ 8'h01, 1'b1, 1'b0);
        drive(m.pred ^ 8'h01, 1'b1, 1'b0);
        check("count_sat", uo_out, 8'hFF);
        drive(m.pred, 1'b1, 1'b0);
        drive(m.pred ^ 8'h01, 1'b1, 1'b0);
        check("count_sat_hold", uo_out, 8'hFF);
        drive(m.pred, 1'b1, 1'b0);
        drive(m.pred ^ 8'h01, 1'b1, 1'b1);
        check("clr_with_err_count", uo_out, 8'h00);
        check("clr_with_err_status", uio_out, 8'h05);
        drive(m.pred, 1'b1, 1'b0);

        // Enable low with garbage on the input.
        held = uo_out;
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom), 1'b0, 1'b0);
            check("ena_low_status", uio_out, 8'h01);
            check("ena_low_count", uo_out, held);
        end
        drive(m.pred, 1'b1, 1'b0);
        check("ena_resume", uio_out, 8'h01);

        // Asynchronous reset while locked.
        drive(m.pred ^ 8'h01, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", uo_out, 8'h00);
        check("async_rst_uio", uio_out, 8'h00);
        #2;
        rst_n = 1'b1;

        // Zero stream never seeds.
        for (int i = 0; i < 5; i++) begin
            drive(8'h00, 1'b1, 1'b0);
            check("zeros_uio", uio_out, 8'h00);
            check("zeros_uo", uo_out, 8'h00);
        end

        // Random traffic: mostly correct words, some corruption, gaps and clears.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] w;
            k = $urandom_range(0, 99);
            if (k < 80)      w = m.pred;
            else if (k < 85) w = 8'h00;
            else if (k < 92) w = m.pred ^ 8'(1 << $urandom_range(0, 7));
            else             w = 8'($urandom);
            drive(w, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
